// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, parity modes, bit-period helper.
// The ST_PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   function automatic int calc_cycle(input int clk_frq, input int baud_rate);
      return clk_frq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; the head is visible on data_o while valid_o is high.
// A push on a full FIFO is accepted only if a pop happens in the same cycle, otherwise overrun_o pulses.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic             overrun_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q, count_d;
   logic             full, do_pop, accept;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign do_pop    = pop_i && (count_q != '0);
   assign accept    = push_i && (!full || do_pop);
   assign overrun_o = push_i && full && !do_pop;

   always_comb begin
      count_d = count_q;
      if (accept && !do_pop) count_d = count_q + 1'b1;
      if (!accept && do_pop) count_d = count_q - 1'b1;
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (accept) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_q] <= data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = count_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, sticky error flags and a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to build the parity state and parity_err; otherwise parity_err is tied 0.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FRQ    = 27000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        rx_in,
   output logic [7:0]                  rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [$clog2(FIFO_DEPTH):0] rx_count,
   output logic                        overrun_err,
   output logic                        frame_err,
   output logic                        parity_err,
   input  logic                        err_clear
);
   localparam int CYCLE = calc_cycle(CLK_FRQ, BAUD_RATE);
   localparam int CW    = $clog2(CYCLE) + 1;
   localparam logic [CW-1:0] SMP0     = CW'(CYCLE/2 - 1);
   localparam logic [CW-1:0] SMP1     = CW'(CYCLE/2);
   localparam logic [CW-1:0] SMP2     = CW'(CYCLE/2 + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CYCLE - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
       (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
       FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_rx_fifo: illegal parameter set");
   end

   logic          sync1_q, sync2_q, prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [1:0]    smp_q, smp_d;
   logic [7:0]    shift_q, shift_d;
   logic          bad_q, bad_d;
   logic          push_q, push_d;
   logic          frame_set, overrun_set;
   logic          frame_err_q, overrun_err_q;
   logic          maj, decide, bit_end;
`ifdef UART_RX_PARITY_EN
   logic          par_set, par_exp, parity_err_q;
   assign par_exp = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
`endif

   assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
   assign decide  = (cnt_q == SMP2);
   assign bit_end = (cnt_q == LAST_CNT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      stop_d    = stop_q;
      smp_d     = smp_q;
      shift_d   = shift_q;
      bad_d     = bad_q;
      push_d    = 1'b0;
      frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_set   = 1'b0;
`endif
      if (cnt_q == SMP0) smp_d[0] = sync2_q;
      if (cnt_q == SMP1) smp_d[1] = sync2_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) begin
               state_d = ST_START;
               shift_d = '0;
               bad_d   = 1'b0;
               bit_d   = '0;
               stop_d  = 1'b0;
            end
         end
         ST_START: begin
            if (decide && maj) state_d = ST_IDLE;
            else if (bit_end)  state_d = ST_DATA;
         end
         ST_DATA: begin
            if (decide) shift_d[bit_q] = maj;
            if (bit_end) begin
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
                  cnt_d = '0;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (decide && (maj != par_exp)) begin
               bad_d   = 1'b1;
               par_set = 1'b1;
            end
            if (bit_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            // Leaving at the last stop decision gives half a bit of slack to catch the next start edge.
            if (decide) begin
               if (!maj) begin
                  bad_d     = 1'b1;
                  frame_set = 1'b1;
               end
               if (stop_q == LAST_STOP) begin
                  state_d = ST_IDLE;
                  push_d  = maj && !bad_q;
               end
            end else if (bit_end) begin
               stop_d = 1'b1;
               cnt_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         prev_q        <= 1'b1;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bit_q         <= '0;
         stop_q        <= 1'b0;
         smp_q         <= '0;
         shift_q       <= '0;
         bad_q         <= 1'b0;
         push_q        <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         sync1_q       <= rx_in;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_q         <= bit_d;
         stop_q        <= stop_d;
         smp_q         <= smp_d;
         shift_q       <= shift_d;
         bad_q         <= bad_d;
         push_q        <= push_d;
         frame_err_q   <= frame_set   | (frame_err_q   & ~err_clear);
         overrun_err_q <= overrun_set | (overrun_err_q & ~err_clear);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!reset_n) parity_err_q <= 1'b0;
      else          parity_err_q <= par_set | (parity_err_q & ~err_clear);
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_i    (push_q),
      .data_i    (shift_q),
      .pop_i     (rx_ready),
      .data_o    (rx_data),
      .valid_o   (rx_valid),
      .count_o   (rx_count),
      .overrun_o (overrun_set)
   );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (default, 4-deep FIFO, 7-bit even parity)
// with per-instance expected-byte queues drained through the rx_valid/rx_ready handshake.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int BIT_T = 234;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       err_clear;
   logic       rx_line [3];
   logic       ready_r [3];
   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic [4:0] count_a;
   logic [2:0] count_b, count_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic       frm_a, frm_b, frm_c;
   logic       par_a, par_b, par_c;

   logic [7:0] exp_q_a[$];
   logic [7:0] exp_q_b[$];
   logic [7:0] exp_q_c[$];
   int n_checks = 0;
   int n_errors = 0;

   uart_rx_fifo dut_a (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_line[0]), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(ready_r[0]), .rx_count(count_a), .overrun_err(ovr_a), .frame_err(frm_a),
      .parity_err(par_a), .err_clear(err_clear)
   );

   uart_rx_fifo #(.FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_line[1]), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(ready_r[1]), .rx_count(count_b), .overrun_err(ovr_b), .frame_err(frm_b),
      .parity_err(par_b), .err_clear(err_clear)
   );

   uart_rx_fifo #(.DATA_BITS(7), .PARITY(PAR_EVEN), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_line[2]), .rx_data(data_c), .rx_valid(valid_c),
      .rx_ready(ready_r[2]), .rx_count(count_c), .overrun_err(ovr_c), .frame_err(frm_c),
      .parity_err(par_c), .err_clear(err_clear)
   );

   function automatic logic [7:0] data_of(input int idx);
      case (idx)
         0:       return data_a;
         1:       return data_b;
         default: return data_c;
      endcase
   endfunction

   function automatic logic valid_of(input int idx);
      case (idx)
         0:       return valid_a;
         1:       return valid_b;
         default: return valid_c;
      endcase
   endfunction

   function automatic int qsize(input int idx);
      case (idx)
         0:       return exp_q_a.size();
         1:       return exp_q_b.size();
         default: return exp_q_c.size();
      endcase
   endfunction

   function automatic logic [7:0] qpop(input int idx);
      case (idx)
         0:       return exp_q_a.pop_front();
         1:       return exp_q_b.pop_front();
         default: return exp_q_c.pop_front();
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int idx, input logic [7:0] d, input int nbits,
                             input int par_bit, input logic stop_v);
      rx_line[idx] = 1'b0;
      idle(BIT_T);
      for (int i = 0; i < nbits; i++) begin
         rx_line[idx] = d[i];
         idle(BIT_T);
      end
      if (par_bit >= 0) begin
         rx_line[idx] = par_bit[0];
         idle(BIT_T);
      end
      rx_line[idx] = stop_v;
      idle(BIT_T);
      rx_line[idx] = 1'b1;
   endtask

   task automatic wait_valid(input int idx, input string tag);
      int k;
      k = 0;
      while (!valid_of(idx) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(valid_of(idx)), 32'd1);
   endtask

   task automatic drain(input int idx, input string tag);
      int n;
      logic [7:0] e;
      n = qsize(idx);
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, 32'(valid_of(idx)), 32'd1);
         e = qpop(idx);
         check({tag, "_data"}, 32'(data_of(idx)), 32'(e));
         ready_r[idx] = 1'b1;
         @(negedge clk);
         ready_r[idx] = 1'b0;
      end
      check({tag, "_empty"}, 32'(valid_of(idx)), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      reset_n   = 1'b0;
      err_clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_line[i] = 1'b1;
         ready_r[i] = 1'b0;
      end
      idle(5);

      // reset state
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_count", 32'(count_a), 32'd0);
      check("rst_data",  32'(data_a),  32'd0);
      check("rst_errs",  32'({ovr_a, frm_a, par_a}), 32'd0);
      check("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
      reset_n = 1'b1;
      idle(20);

      // single good frame 0xA5, 8N1
      exp_q_a.push_back(8'hA5);
      send_frame(0, 8'hA5, 8, -1, 1'b1);
      wait_valid(0, "a5_valid");
      check("a5_count", 32'(count_a), 32'd1);
      drain(0, "a5");
      check("a5_count_after", 32'(count_a), 32'd0);

      // stop bit forced low
      send_frame(0, 8'h3C, 8, -1, 1'b0);
      idle(10);
      check("frm_set",   32'(frm_a),   32'd1);
      check("frm_count", 32'(count_a), 32'd0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("frm_clear", 32'(frm_a), 32'd0);

      // 50-clock low glitch on idle line
      rx_line[0] = 1'b0;
      idle(50);
      rx_line[0] = 1'b1;
      idle(300);
      check("glitch_count", 32'(count_a), 32'd0);
      check("glitch_errs",  32'({ovr_a, frm_a, par_a}), 32'd0);
      check("glitch_state", 32'(dut_a.state_q), 32'(ST_IDLE));

      // reset pulse during bit 4 of 0xFF, then 0x12
      rx_line[0] = 1'b0;
      idle(BIT_T);
      rx_line[0] = 1'b1;
      idle(4 * BIT_T + 117);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      idle(117 + 4 * BIT_T);
      check("rstmid_count", 32'(count_a), 32'd0);
      exp_q_a.push_back(8'h12);
      send_frame(0, 8'h12, 8, -1, 1'b1);
      wait_valid(0, "x12_valid");
      check("x12_count", 32'(count_a), 32'd1);
      drain(0, "x12");

      // random back-to-back bytes
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q_a.push_back(b);
         send_frame(0, b, 8, -1, 1'b1);
      end
      idle(5);
      check("rnd_count", 32'(count_a), 32'd3);
      drain(0, "rnd");
      check("a_no_ovr", 32'(ovr_a), 32'd0);

      // overrun on a 4-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q_b.push_back(8'(i));
         send_frame(1, 8'(i), 8, -1, 1'b1);
      end
      idle(5);
      check("ovr_count", 32'(count_b), 32'd4);
      check("ovr_flag",  32'(ovr_b),   32'd1);
      drain(1, "ovr");
      check("ovr_sticky", 32'(ovr_b), 32'd1);

`ifdef UART_RX_PARITY_EN
      // 7E1: good parity then bad parity
      exp_q_c.push_back(8'h55);
      send_frame(2, 8'h55, 7, 0, 1'b1);
      send_frame(2, 8'h55, 7, 1, 1'b1);
      idle(5);
      check("par_flag",  32'(par_c),   32'd1);
      check("par_frm",   32'(frm_c),   32'd0);
      check("par_count", 32'(count_c), 32'd1);
      drain(2, "par");
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("par_clear", 32'(par_c), 32'd0);
`else
      // parity logic absent: 7-bit frame with no parity bit
      exp_q_c.push_back(8'h55);
      send_frame(2, 8'h55, 7, -1, 1'b1);
      idle(5);
      check("nopar_flag",  32'(par_c),   32'd0);
      check("nopar_count", 32'(count_c), 32'd1);
      drain(2, "nopar");
`endif
      check("c_no_ovr", 32'(ovr_c), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FRQ, default 27000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate; CYCLE = CLK_FRQ/BAUD_RATE clocks per bit.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal values 5..8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, legal values 1..2.
REQ-005 SHALL have parameter PARITY, default 0, values 0 none / 1 even / 2 odd; effective only per REQ-024.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, a power of two, 2..256.
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- rx_in  in  1  serial input, idle high
- rx_data  out  8  FIFO head byte, unused MSBs zero
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer pops head
- rx_count  out  $clog2(FIFO_DEPTH)+1  bytes held
- overrun_err  out  1  sticky, byte dropped on full FIFO
- frame_err  out  1  sticky, stop bit sampled low
- parity_err  out  1  sticky, parity mismatch
- err_clear  in  1  clears all sticky errors

Function
REQ-008 rx_in SHALL pass through a 2-flop synchronizer; a start is detected on a synchronized 1->0 transition in IDLE.
REQ-009 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when parity is disabled.
REQ-010 Each bit SHALL be resolved by 2-of-3 majority of samples at bit-cycle counts CYCLE/2-1, CYCLE/2, CYCLE/2+1.
REQ-011 START SHALL return to IDLE without any push or error if its majority value is 1 (false start).
REQ-012 DATA SHALL capture DATA_BITS bits LSB first; bits above DATA_BITS-1 of the stored byte SHALL be 0.
REQ-013 STOP SHALL check STOP_BITS stop bits; after the last stop-bit majority decision, FSM SHALL enter IDLE on the next clock (half-bit early, for resync).
REQ-014 Any stop bit resolving to 0 SHALL set frame_err and discard the byte.
REQ-015 Parity mismatch SHALL set parity_err and discard the byte.
REQ-016 A good frame SHALL be pushed in the cycle after its final stop decision; rx_valid SHALL rise the following cycle when the FIFO was empty.
REQ-017 FIFO SHALL be show-ahead: rx_data equals the head whenever rx_valid=1; a pop occurs when rx_valid and rx_ready are both 1.
REQ-018 A push on a full FIFO with no pop SHALL drop the byte and set overrun_err; a push with a simultaneous pop on a full FIFO SHALL be accepted.
REQ-019 rx_ready while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 Error set and err_clear in the same cycle: set SHALL win.
REQ-021 Bit counter SHALL be $clog2(CYCLE)+1 bits wide and reset to 0 on every state change.

Reset
REQ-022 With reset_n low at a clk edge: FSM to IDLE, FIFO empty, rx_valid=0, rx_count=0, rx_data=0, all error flags=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abandon the frame with no push; reception resumes at the next falling edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the PARITY state and parity_err logic SHALL be present. Undefined: PARITY is ignored, the PARITY state is absent, and parity_err SHALL be tied 0.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum, parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a CYCLE helper function.
REQ-026 FIFO SHALL be sub-module uart_sync_fifo (parameters WIDTH, DEPTH; show-ahead, count output).

Verification (CLK_FRQ=27000000, BAUD_RATE=115200, CYCLE=234)
REQ-027 Send 0xA5, 8N1 -> rx_valid rises; rx_data=0xA5; rx_count=1; pop -> rx_valid=0.
REQ-028 DATA_BITS=7, PARITY=1 (even), macro on: send 0x55 with correct parity, then 0x55 with wrong parity -> one byte 0x55 stored, parity_err=1.
REQ-029 FIFO_DEPTH=4: send 5 bytes 0x01..0x05, no pops -> rx_count=4, overrun_err=1, pops return 0x01..0x04.
REQ-030 Stop bit forced low on 0x3C -> no push, frame_err=1; err_clear -> 0.
REQ-031 Low glitch of 50 clocks on idle line -> no push, no error, FSM in IDLE.
REQ-032 reset_n pulsed during bit 4 of 0xFF, then 0x12 sent -> only 0x12 received.
